rc5_core_param: RTL and testbench

Parametrised RC5-w/r/b block cipher engine, successor to the fixed 32-bit/128-bit-key algo core. Word width, maximum rounds and key length are generics. Internal key expansion builds the S table from a raw key. Valid/ready streaming handshakes replace the encrypt/decrypt/done pulses. Iterative datapath, one half-round per clock; sits between the host register interface and the data mover.

---
 rtl/rc5_core_param_if.sv | 13 +
 rtl/rc5_core_param.sv | 256 +++++++++++++++++++++++++
 tb/tb_rc5_core_param.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rc5_core_param_if.sv
// Block stream handshake for rc5_core_param: input block (valid/ready) and result (valid/ready).
interface rc5_core_param_if #(parameter int unsigned W = 32);
    logic           in_valid;
    logic           in_ready;
    logic           mode;
    logic [2*W-1:0] d_in;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] d_out;

    modport master (output in_valid, mode, d_in, out_ready, input in_ready, out_valid, d_out);
    modport slave  (input in_valid, mode, d_in, out_ready, output in_ready, out_valid, d_out);
endinterface

// File: rtl/rc5_core_param.sv
// Iterative RC5-w/r/b engine with on-chip key expansion, one half-round per clock.
// Optional RC5_ZEROIZE_EN adds a zeroize input that aborts work and wipes key material.
module rc5_core_param #(
    parameter int unsigned W          = 32,
    parameter int unsigned MAX_ROUNDS = 20,
    parameter int unsigned KEY_BYTES  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             key_load,
    input  logic [8*KEY_BYTES-1:0]           key,
    input  logic [$clog2(MAX_ROUNDS+1)-1:0]  num_rounds,
    output logic                             key_ready,
    output logic                             err,
    output logic                             busy,
`ifdef RC5_ZEROIZE_EN
    input  logic                             zeroize,
`endif
    rc5_core_param_if.slave                  bus
);
    localparam int unsigned LGW     = $clog2(W);
    localparam int unsigned RW      = $clog2(MAX_ROUNDS + 1);
    localparam int unsigned T_MAX   = 2 * MAX_ROUNDS + 2;
    localparam int unsigned IW      = $clog2(T_MAX);
    localparam int unsigned BPW     = W / 8;
    localparam int unsigned C       = (KEY_BYTES + BPW - 1) / BPW;
    localparam int unsigned JW      = (C > 1) ? $clog2(C) : 1;
    localparam int unsigned MIX_MAX = 3 * ((T_MAX > C) ? T_MAX : C);
    localparam int unsigned CW      = $clog2(MIX_MAX + 1);
    localparam int unsigned KPW     = W * C;

    localparam logic [W-1:0] P = (W == 16) ? W'(16'hB7E1) : (W == 32) ? W'(32'hB7E15163)
                                                          : W'(64'hB7E151628AED2A6B);
    localparam logic [W-1:0] Q = (W == 16) ? W'(16'h9E37) : (W == 32) ? W'(32'h9E3779B9)
                                                          : W'(64'h9E3779B97F4A7C15);

    typedef enum logic [2:0] {
        IDLE, KEY_INIT, KEY_MIX, READY, LOAD, ROUND, OUT
`ifdef RC5_ZEROIZE_EN
        , ZERO
`endif
    } state_t;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LGW-1:0] n);
        return (x << n) | (x >> (W - n));
    endfunction

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [LGW-1:0] n);
        return (x >> n) | (x << (W - n));
    endfunction

    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] mi;
    logic [JW-1:0] mj;
    logic [W-1:0]  ka, kb, a, b;
    logic          md;
    logic [RW-1:0] rr;

    logic [W-1:0]  s_tab [T_MAX];
    logic [W-1:0]  l_tab [C];

    logic [KPW-1:0] key_pad;
    logic [CW-1:0]  t_cur, mix_len;
    logic [W-1:0]   mix_a, mix_ab, mix_b;
    logic [IW-1:0]  r_idx;
    logic [W-1:0]   s_rnd, a_nxt, b_nxt;
    logic           last_step, key_take;

    assign key_pad = KPW'(key);
    assign t_cur   = CW'({rr, 1'b0}) + CW'(2);
    assign mix_len = CW'(3) * ((t_cur > CW'(C)) ? t_cur : CW'(C));

    // One key-mixing step: A = S[i] = (S[i]+A+B) <<< 3, B = L[j] = (L[j]+A+B) <<< (A+B)
    assign mix_a  = rotl(s_tab[mi] + ka + kb, LGW'(3));
    assign mix_ab = mix_a + kb;
    assign mix_b  = rotl(l_tab[mj] + mix_ab, mix_ab[LGW-1:0]);

    assign key_take = key_load && (state == IDLE || state == READY)
                      && !(num_rounds > RW'(MAX_ROUNDS))
`ifdef RC5_ZEROIZE_EN
                      && !zeroize
`endif
                      ;

    // Step cnt of a block: encrypt whitens at 0, decrypt unwhitens at 2r; odd steps touch A
    always_comb begin
        r_idx     = md ? (IW'({rr, 1'b0}) + IW'(1) - IW'(cnt)) : (IW'(cnt) + IW'(1));
        last_step = (cnt == CW'({rr, 1'b0}));
        s_rnd     = s_tab[r_idx];
        a_nxt     = a;
        b_nxt     = b;
        if (!md) begin
            if (cnt == '0) begin
                a_nxt = a + s_tab[0];
                b_nxt = b + s_tab[1];
            end else if (cnt[0]) begin
                a_nxt = rotl(a ^ b, b[LGW-1:0]) + s_rnd;
            end else begin
                b_nxt = rotl(b ^ a, a[LGW-1:0]) + s_rnd;
            end
        end else begin
            if (last_step) begin
                a_nxt = a - s_tab[0];
                b_nxt = b - s_tab[1];
            end else if (cnt[0]) begin
                a_nxt = rotr(a - s_rnd, b[LGW-1:0]) ^ b;
            end else begin
                b_nxt = rotr(b - s_rnd, a[LGW-1:0]) ^ a;
            end
        end
    end

    // Key tables carry no reset; contents are only trusted once key_ready is set
    always_ff @(posedge clk) begin
        if (state == KEY_INIT)
            s_tab[IW'(cnt)] <= ka;
        else if (state == KEY_MIX)
            s_tab[mi] <= mix_a;
`ifdef RC5_ZEROIZE_EN
        else if (state == ZERO)
            s_tab[IW'(cnt)] <= '0;
`endif

        if (key_take) begin
            for (int k = 0; k < C; k++) l_tab[k] <= key_pad[k*W +: W];
        end else if (state == KEY_MIX) begin
            l_tab[mj] <= mix_b;
        end
`ifdef RC5_ZEROIZE_EN
        else if (state == ZERO && cnt == '0) begin
            for (int k = 0; k < C; k++) l_tab[k] <= '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            mi            <= '0;
            mj            <= '0;
            ka            <= '0;
            kb            <= '0;
            a             <= '0;
            b             <= '0;
            md            <= 1'b0;
            rr            <= '0;
            key_ready     <= 1'b0;
            err           <= 1'b0;
            busy          <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.d_out     <= '0;
        end
`ifdef RC5_ZEROIZE_EN
        else if (zeroize) begin
            state         <= ZERO;
            cnt           <= '0;
            ka            <= '0;
            kb            <= '0;
            a             <= '0;
            b             <= '0;
            key_ready     <= 1'b0;
            busy          <= 1'b1;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.d_out     <= '0;
        end
`endif
        else begin
            case (state)
                IDLE, READY: begin
                    if (key_load) begin
                        key_ready    <= 1'b0;
                        bus.in_ready <= 1'b0;
                        if (num_rounds > RW'(MAX_ROUNDS)) begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            err   <= 1'b0;
                            rr    <= num_rounds;
                            cnt   <= '0;
                            ka    <= P;
                            busy  <= 1'b1;
                            state <= KEY_INIT;
                        end
                    end else if (state == READY && bus.in_valid && bus.in_ready) begin
                        a            <= bus.d_in[W-1:0];
                        b            <= bus.d_in[2*W-1:W];
                        md           <= bus.mode;
                        cnt          <= '0;
                        bus.in_ready <= 1'b0;
                        busy         <= 1'b1;
                        state        <= LOAD;
                    end
                end
                KEY_INIT: begin
                    ka  <= ka + Q;
                    cnt <= cnt + CW'(1);
                    if (cnt == t_cur - CW'(1)) begin
                        cnt   <= '0;
                        ka    <= '0;
                        kb    <= '0;
                        mi    <= '0;
                        mj    <= '0;
                        state <= KEY_MIX;
                    end
                end
                KEY_MIX: begin
                    ka  <= mix_a;
                    kb  <= mix_b;
                    mi  <= (mi == IW'(t_cur - CW'(1))) ? '0 : mi + IW'(1);
                    mj  <= (mj == JW'(C - 1)) ? '0 : mj + JW'(1);
                    cnt <= cnt + CW'(1);
                    if (cnt == mix_len - CW'(1)) begin
                        key_ready    <= 1'b1;
                        bus.in_ready <= 1'b1;
                        busy         <= 1'b0;
                        state        <= READY;
                    end
                end
                LOAD, ROUND: begin
                    a   <= a_nxt;
                    b   <= b_nxt;
                    cnt <= cnt + CW'(1);
                    if (last_step) begin
                        bus.out_valid <= 1'b1;
                        bus.d_out     <= {b_nxt, a_nxt};
                        state         <= OUT;
                    end else begin
                        state <= ROUND;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        busy          <= 1'b0;
                        state         <= READY;
                    end
                end
`ifdef RC5_ZEROIZE_EN
                ZERO: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(T_MAX - 1)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rc5_core_param.sv
// Directed bench for rc5_core_param (W=32, MAX_ROUNDS=20, KEY_BYTES=16) using RC5-32/12/16 vectors.
module tb_rc5_core_param;
    localparam logic [63:0] CT0  = 64'h6D8F4B15_EEDBA521;
    localparam logic [63:0] CT1  = 64'h52892B5B_AC13C0F7;
    localparam logic [127:0] KEY1 = 128'h91CEA91001A5556351B241BE19465F91;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_load;
    logic [127:0] key;
    logic [4:0]   num_rounds;
    logic         key_ready, err, busy;
`ifdef RC5_ZEROIZE_EN
    logic         zeroize;
`endif
    int checks = 0;
    int errors = 0;
    int lat;
    logic [63:0] s01;

    rc5_core_param_if #(.W(32)) bus ();

    rc5_core_param #(.W(32), .MAX_ROUNDS(20), .KEY_BYTES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_load   (key_load),
        .key        (key),
        .num_rounds (num_rounds),
        .key_ready  (key_ready),
        .err        (err),
        .busy       (busy),
`ifdef RC5_ZEROIZE_EN
        .zeroize    (zeroize),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] x, input logic [4:0] n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Reference RC5-32 key schedule, returning {S[1], S[0]}
    function automatic logic [63:0] ref_s01(input logic [127:0] k, input int r);
        logic [31:0] s [42];
        logic [31:0] l [4];
        logic [31:0] ra, rb;
        int t, i, j;
        t = 2 * r + 2;
        for (int n = 0; n < 4; n++) l[n] = k[32*n +: 32];
        s[0] = 32'hB7E15163;
        for (int n = 1; n < t; n++) s[n] = s[n-1] + 32'h9E3779B9;
        ra = '0; rb = '0; i = 0; j = 0;
        for (int n = 0; n < 3 * ((t > 4) ? t : 4); n++) begin
            s[i] = rol(s[i] + ra + rb, 5'd3);
            ra   = s[i];
            l[j] = rol(l[j] + ra + rb, 5'(ra + rb));
            rb   = l[j];
            i = (i + 1) % t;
            j = (j + 1) % 4;
        end
        return {s[1], s[0]};
    endfunction

    task automatic load_key(input logic [127:0] k, input logic [4:0] r, output int n);
        key = k;
        num_rounds = r;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        n = 0;
        while (!key_ready && n < 2000) begin
            tick();
            n++;
        end
    endtask

    task automatic run_block(input logic m, input logic [63:0] din, output int n);
        int w;
        bus.mode = m;
        bus.d_in = din;
        bus.in_valid = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 100) begin
            tick();
            w++;
        end
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        rst = 1'b1;
        key_load = 1'b0;
        key = '0;
        num_rounds = '0;
        bus.in_valid = 1'b0;
        bus.mode = 1'b0;
        bus.d_in = '0;
        bus.out_ready = 1'b1;
`ifdef RC5_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        tick();
        tick();
        chk("rst_key_ready", 64'(key_ready), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_d_out", bus.d_out, 64'd0);
        rst = 1'b0;
        tick();

        // Zero key, r=12, encrypt zero block
        load_key('0, 5'd12, lat);
        chk("key_lat_r12", 64'(lat), 64'd104);
        chk("key_busy_done", 64'(busy), 64'd0);
        chk("key_in_ready", 64'(bus.in_ready), 64'd1);
        run_block(1'b0, 64'd0, lat);
        chk("enc0_lat", 64'(lat), 64'd25);
        chk("enc0_d_out", bus.d_out, CT0);
        chk("enc0_busy", 64'(busy), 64'd1);
        tick();
        chk("enc0_out_valid_drop", 64'(bus.out_valid), 64'd0);
        chk("enc0_in_ready_back", 64'(bus.in_ready), 64'd1);

        // Second vector, then its decryption
        load_key(KEY1, 5'd12, lat);
        chk("key1_lat", 64'(lat), 64'd104);
        run_block(1'b0, CT0, lat);
        chk("enc1_lat", 64'(lat), 64'd25);
        chk("enc1_d_out", bus.d_out, CT1);
        tick();
        run_block(1'b1, CT1, lat);
        chk("dec1_lat", 64'(lat), 64'd25);
        chk("dec1_d_out", bus.d_out, CT0);
        tick();

        // Backpressure: result held, no second accept while stalled
        bus.out_ready = 1'b0;
        run_block(1'b0, CT0, lat);
        chk("hold_lat", 64'(lat), 64'd25);
        bus.in_valid = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            chk("hold_d_out", bus.d_out, CT1);
            chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("release_out_valid", 64'(bus.out_valid), 64'd0);
        chk("release_in_ready", 64'(bus.in_ready), 64'd1);
        chk("release_busy", 64'(busy), 64'd0);

        // Illegal round count
        key = '0;
        num_rounds = 5'd21;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        chk("bad_r_err", 64'(err), 64'd1);
        chk("bad_r_key_ready", 64'(key_ready), 64'd0);
        chk("bad_r_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        tick();
        chk("bad_r_err_sticky", 64'(err), 64'd1);

        // r=0: whitening only
        load_key('0, 5'd0, lat);
        chk("key_lat_r0", 64'(lat), 64'd14);
        chk("r0_err_clear", 64'(err), 64'd0);
        s01 = ref_s01('0, 0);
        run_block(1'b0, 64'd0, lat);
        chk("r0_enc_lat", 64'(lat), 64'd1);
        chk("r0_enc_d_out", bus.d_out, s01);
        tick();
        run_block(1'b1, s01, lat);
        chk("r0_dec_lat", 64'(lat), 64'd1);
        chk("r0_dec_d_out", bus.d_out, 64'd0);
        tick();

        // Async reset in the middle of a block
        load_key('0, 5'd12, lat);
        chk("key_lat_pre_rst", 64'(lat), 64'd104);
        run_block(1'b0, 64'd0, lat);
        tick();
        bus.d_in = 64'd0;
        bus.mode = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        chk("mid_busy", 64'(busy), 64'd1);
        chk("mid_d_out_prev", bus.d_out, CT0);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_key_ready", 64'(key_ready), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_d_out", bus.d_out, 64'd0);
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b1;
        repeat (5) tick();
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
        bus.in_valid = 1'b0;
        load_key('0, 5'd12, lat);
        chk("rekey_lat", 64'(lat), 64'd104);
        run_block(1'b0, 64'd0, lat);
        chk("rekey_d_out", bus.d_out, CT0);
        tick();

`ifdef RC5_ZEROIZE_EN
        begin
            int n;
            logic ov_seen;
            bus.d_in = 64'd0;
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            repeat (5) tick();
            zeroize = 1'b1;
            tick();
            zeroize = 1'b0;
            n = 0;
            ov_seen = bus.out_valid;
            while (busy && n < 200) begin
                tick();
                n++;
                ov_seen = ov_seen | bus.out_valid;
            end
            chk("zero_busy_len", 64'(n), 64'd42);
            chk("zero_no_out_valid", 64'(ov_seen), 64'd0);
            chk("zero_d_out", bus.d_out, 64'd0);
            chk("zero_key_ready", 64'(key_ready), 64'd0);
            load_key('0, 5'd12, lat);
            chk("zero_rekey_lat", 64'(lat), 64'd104);
            run_block(1'b0, 64'd0, lat);
            chk("zero_rekey_d_out", bus.d_out, CT0);
            tick();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
